// File: rtl/cam_pkg.sv
// cam_block_buffer shared constants and types.
// Fixed sensor geometry, pulse timing and read-engine states.
package cam_pkg;

  localparam int ROW_PX           = 128;
  localparam int ROW_BYTES        = ROW_PX / 4;
  localparam int BLOCK_ROWS       = 8;
  localparam int BLOCK_BYTES      = ROW_BYTES * BLOCK_ROWS;
  localparam int BLOCKS_PER_FRAME = 16;
  localparam int RDY_PULSE        = 16;
  localparam int RD_LAT           = 2;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_FETCH = 2'd1,
    RD_HOLD  = 2'd2
  } rd_state_e;

endpackage

// File: rtl/cam_bank_ram.sv
// Two-bank block store: 512x8 simple dual-port RAM.
// Ports: clk_i; we_i/waddr_i/wdata_i write; raddr_i in, rdata_o registered out.
module cam_bank_ram
  import cam_pkg::*;
(
  input  logic       clk_i,
  input  logic       we_i,
  input  logic [8:0] waddr_i,
  input  logic [7:0] wdata_i,
  input  logic [8:0] raddr_i,
  output logic [7:0] rdata_o
);

  logic [7:0] mem_q [2*BLOCK_BYTES];
  logic [7:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/cam_block_buffer.sv
// Ping-pong 8-row block buffer: packs 2-bit pixels, publishes blocks, serves reads.
// Ports: sys_clock/sys_resetn/NewRunReset; Frame_Start/Pix_*; Reader_Busy;
//   BlockDataReady/Frame_Done/Overrun; RequestReadBuffer/ReadBufferOffset ->
//   BufferReadResult/BufferDataReady.
module cam_block_buffer
  import cam_pkg::*;
(
  input  logic       sys_clock,
  input  logic       sys_resetn,
  input  logic       NewRunReset,
  input  logic       Frame_Start,
  input  logic       Pix_Valid,
  input  logic [1:0] Pix_Data,
  input  logic       Reader_Busy,
  output logic       BlockDataReady,
  input  logic       RequestReadBuffer,
  input  logic [9:0] ReadBufferOffset,
  output logic [7:0] BufferReadResult,
  output logic       BufferDataReady,
  output logic       Overrun,
  output logic       Frame_Done
);

  logic rst;
  assign rst = !sys_resetn || NewRunReset;

  // write side state
  logic [6:0] x_q, x_d;
  logic [2:0] row_q, row_d;
  logic [3:0] blk_q, blk_d;
  logic [5:0] sh_q, sh_d;
  logic       done_q, done_d;
  logic       wr_bank_q, wr_bank_d;
  logic       rd_bank_q, rd_bank_d;
  logic       pend_q, pend_d;
  logic       pend_bank_q, pend_bank_d;
  logic       pend_last_q, pend_last_d;
  logic       ovr_q, ovr_d;
  logic       bdr_q, bdr_d;
  logic       gap_q, gap_d;
  logic [3:0] pcnt_q, pcnt_d;
  logic       fd_q, fd_d;

  // Frame_Start acts on the same cycle's pixel, so counters are
  // viewed through this cleared lens before use.
  logic [6:0] x_c;
  logic [2:0] row_c;
  logic [3:0] blk_c;
  logic [5:0] sh_c;
  logic       done_c, pend_c;
  logic       pix_ok, row_end, blk_end, last_c;
  logic       gap_ok, can_pub, pub_now, pub_pend, publish;
  logic       ram_we;
  logic [8:0] ram_waddr;
  logic [7:0] ram_wdata;

  assign x_c    = Frame_Start ? '0 : x_q;
  assign row_c  = Frame_Start ? '0 : row_q;
  assign blk_c  = Frame_Start ? '0 : blk_q;
  assign sh_c   = Frame_Start ? '0 : sh_q;
  assign done_c = Frame_Start ? 1'b0 : done_q;
  assign pend_c = Frame_Start ? 1'b0 : pend_q;

  assign pix_ok  = Pix_Valid && !done_c;
  assign row_end = x_c == 7'(ROW_PX - 1);
  assign blk_end = pix_ok && row_end
                && row_c == 3'(BLOCK_ROWS - 1);
  assign last_c  = blk_c == 4'(BLOCKS_PER_FRAME - 1);

  assign ram_we    = pix_ok && x_c[1:0] == 2'd3;
  assign ram_waddr = {wr_bank_q, row_c, x_c[6:2]};
  assign ram_wdata = {sh_c, Pix_Data};

  // Pulse may start only once the previous high and low phases are done.
  assign gap_ok   = !bdr_q
                 && (!gap_q || pcnt_q == 4'(RDY_PULSE - 1));
  assign pub_pend = pend_c && !Reader_Busy && gap_ok;
  assign can_pub  = !pend_c && !Reader_Busy && gap_ok;
  assign pub_now  = blk_end && can_pub;
  assign publish  = pub_pend || pub_now;

  always_comb begin
    x_d         = x_c;
    row_d       = row_c;
    blk_d       = blk_c;
    sh_d        = sh_c;
    done_d      = done_c;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    pend_d      = pend_c;
    pend_bank_d = pend_bank_q;
    pend_last_d = pend_last_q;
    ovr_d       = Frame_Start ? 1'b0 : ovr_q;
    bdr_d       = bdr_q;
    gap_d       = gap_q;
    pcnt_d      = pcnt_q;
    fd_d        = 1'b0;

    if (pix_ok) begin
      sh_d = {sh_c[3:0], Pix_Data};
      x_d  = x_c + 7'd1;
      if (row_end) row_d = row_c + 3'd1;
      if (blk_end) begin
        blk_d = blk_c + 4'd1;
        if (last_c) done_d = 1'b1;
      end
    end

    if (pub_pend) begin
      rd_bank_d = pend_bank_q;
      pend_d    = 1'b0;
    end

    // A pending block moves writes to the other bank so the pending
    // data survives; a drop keeps writing the same bank.
    if (blk_end) begin
      if (pend_c) begin
        ovr_d = 1'b1;
      end else if (can_pub) begin
        rd_bank_d = wr_bank_q;
        wr_bank_d = !wr_bank_q;
      end else begin
        pend_d      = 1'b1;
        pend_bank_d = wr_bank_q;
        pend_last_d = last_c;
        wr_bank_d   = !wr_bank_q;
      end
    end

    if (publish) begin
      bdr_d  = 1'b1;
      gap_d  = 1'b0;
      pcnt_d = '0;
      fd_d   = pub_pend ? pend_last_q : last_c;
    end else if (bdr_q) begin
      if (pcnt_q == 4'(RDY_PULSE - 1)) begin
        bdr_d  = 1'b0;
        gap_d  = 1'b1;
        pcnt_d = '0;
      end else begin
        pcnt_d = pcnt_q + 4'd1;
      end
    end else if (gap_q) begin
      if (pcnt_q == 4'(RDY_PULSE - 1)) gap_d = 1'b0;
      else pcnt_d = pcnt_q + 4'd1;
    end
  end

  always_ff @(posedge sys_clock) begin
    if (rst) begin
      x_q         <= '0;
      row_q       <= '0;
      blk_q       <= '0;
      sh_q        <= '0;
      done_q      <= 1'b0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b1;
      pend_q      <= 1'b0;
      pend_bank_q <= 1'b0;
      pend_last_q <= 1'b0;
      ovr_q       <= 1'b0;
      bdr_q       <= 1'b0;
      gap_q       <= 1'b0;
      pcnt_q      <= '0;
      fd_q        <= 1'b0;
    end else begin
      x_q         <= x_d;
      row_q       <= row_d;
      blk_q       <= blk_d;
      sh_q        <= sh_d;
      done_q      <= done_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      pend_q      <= pend_d;
      pend_bank_q <= pend_bank_d;
      pend_last_q <= pend_last_d;
      ovr_q       <= ovr_d;
      bdr_q       <= bdr_d;
      gap_q       <= gap_d;
      pcnt_q      <= pcnt_d;
      fd_q        <= fd_d;
    end
  end

  // read engine
  rd_state_e  st_q, st_d;
  logic [1:0] lat_q, lat_d;
  logic [9:0] off_q, off_d;
  logic [7:0] rdat_q, rdat_d;
  logic       rdy_q, rdy_d;
  logic [7:0] ram_rdata;

  always_comb begin
    st_d   = st_q;
    lat_d  = lat_q;
    off_d  = off_q;
    rdat_d = rdat_q;
    rdy_d  = rdy_q;
    unique case (1'b1)
      st_q == RD_IDLE: begin
        if (RequestReadBuffer && !rdy_q) begin
          off_d = ReadBufferOffset;
          lat_d = '0;
          st_d  = RD_FETCH;
        end
      end
      st_q == RD_FETCH: begin
        if (lat_q == 2'(RD_LAT - 1)) begin
          rdat_d = (off_q[9:8] != 2'd0) ? 8'h00 : ram_rdata;
          rdy_d  = 1'b1;
          st_d   = RD_HOLD;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      st_q == RD_HOLD: begin
        if (!RequestReadBuffer) begin
          rdy_d = 1'b0;
          st_d  = RD_IDLE;
        end
      end
      default: begin
        rdy_d = 1'b0;
        st_d  = RD_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clock) begin
    if (rst) begin
      st_q   <= RD_IDLE;
      lat_q  <= '0;
      off_q  <= '0;
      rdat_q <= '0;
      rdy_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      lat_q  <= lat_d;
      off_q  <= off_d;
      rdat_q <= rdat_d;
      rdy_q  <= rdy_d;
    end
  end

  cam_bank_ram u_ram (
    .clk_i   (sys_clock),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .raddr_i ({rd_bank_q, off_q[7:0]}),
    .rdata_o (ram_rdata)
  );

  assign BlockDataReady   = bdr_q;
  assign Frame_Done       = fd_q;
  assign Overrun          = ovr_q;
  assign BufferReadResult = rdat_q;
  assign BufferDataReady  = rdy_q;

endmodule

// File: tb/tb_cam_block_buffer.sv
// Directed bench for cam_block_buffer.
// Hand-computed block contents, pulse timing and read handshake checks.
module tb_cam_block_buffer;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       nrr = 1'b0;
  logic       fs = 1'b0;
  logic       pv = 1'b0;
  logic [1:0] pd = 2'd0;
  logic       busy = 1'b0;
  logic       bdr;
  logic       req = 1'b0;
  logic [9:0] off = 10'd0;
  logic [7:0] rres;
  logic       rdy;
  logic       ovr;
  logic       fdone;

  int checks = 0;
  int fails = 0;

  int rises = 0, fdc = 0;
  int hi_len = 0, lo_len = 0;
  int min_hi = 1000, max_hi = 0, min_gap = 1000;
  bit seen_fall = 0, prev_bdr = 0;
  int r0, f0;

  always #5 clk = ~clk;

  cam_block_buffer dut (
    .sys_clock         (clk),
    .sys_resetn        (rstn),
    .NewRunReset       (nrr),
    .Frame_Start       (fs),
    .Pix_Valid         (pv),
    .Pix_Data          (pd),
    .Reader_Busy       (busy),
    .BlockDataReady    (bdr),
    .RequestReadBuffer (req),
    .ReadBufferOffset  (off),
    .BufferReadResult  (rres),
    .BufferDataReady   (rdy),
    .Overrun           (ovr),
    .Frame_Done        (fdone)
  );

  always @(negedge clk) begin
    if (fdone) fdc++;
    if (bdr && !prev_bdr) begin
      rises++;
      if (seen_fall && lo_len < min_gap) min_gap = lo_len;
      hi_len = 1;
    end else if (bdr) begin
      hi_len++;
    end else if (prev_bdr) begin
      if (hi_len < min_hi) min_hi = hi_len;
      if (hi_len > max_hi) max_hi = hi_len;
      lo_len = 1;
      seen_fall = 1;
    end else begin
      lo_len++;
    end
    prev_bdr = bdr;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // mode 0: ramp; 1: byte value == byte index; 2..5: constant 0..3
  function automatic logic [1:0] pixv(input int mode, input int n);
    int b;
    b = (n >> 2) & 255;
    if (mode == 0) return 2'(n & 3);
    if (mode == 1) return 2'((b >> (6 - 2 * (n & 3))) & 3);
    return 2'(mode - 2);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic feed(input int start, input int n,
                      input int mode, input bit fs0);
    for (int i = 0; i < n; i++) begin
      pv = 1'b1;
      pd = pixv(mode, start + i);
      fs = fs0 && (i == 0);
      tick(1);
    end
    pv = 1'b0;
    fs = 1'b0;
  endtask

  task automatic fs_pulse();
    fs = 1'b1;
    tick(1);
    fs = 1'b0;
  endtask

  // Called #1 after an edge with req low; leaves req low, ready low.
  task automatic rd(input string tag, input logic [9:0] o,
                    input logic [7:0] exp);
    req = 1'b1;
    off = o;
    tick(2);
    check({tag, "_early"}, 32'(rdy), 32'd0);
    tick(1);
    check({tag, "_rdy"}, 32'(rdy), 32'd1);
    check({tag, "_data"}, 32'(rres), 32'(exp));
    req = 1'b0;
    tick(1);
    check({tag, "_drop"}, 32'(rdy), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    check("rst_bdr", 32'(bdr), 32'd0);
    check("rst_rdy", 32'(rdy), 32'd0);
    check("rst_ovr", 32'(ovr), 32'd0);
    check("rst_fd", 32'(fdone), 32'd0);
    check("rst_data", 32'(rres), 32'd0);
    rstn = 1'b1;
    tick(2);

    // ramp block
    fs_pulse();
    feed(0, 1024, 0, 0);
    check("ramp_pub", 32'(bdr), 32'd1);
    tick(40);
    check("ramp_pulses", 32'(rises), 32'd1);
    check("ramp_ovr", 32'(ovr), 32'd0);
    rd("ramp0", 10'h000, 8'h1B);
    rd("rampff", 10'h0FF, 8'h1B);

    // index pattern block and handshake
    fs_pulse();
    feed(0, 1024, 1, 0);
    check("idx_pub", 32'(bdr), 32'd1);
    tick(20);
    rd("rd21", 10'h021, 8'h21);
    rd("rd22", 10'h022, 8'h22);
    rd("rd100", 10'h100, 8'h00);
    rd("rd3ff", 10'h3FF, 8'h00);
    rd("rdc3", 10'h0C3, 8'hC3);

    // pending and overrun
    fs_pulse();
    r0 = rises;
    feed(0, 1024, 2, 0);
    check("p0_pub", 32'(bdr), 32'd1);
    busy = 1'b1;
    feed(0, 1024, 3, 0);
    check("p1_pend", 32'(bdr), 32'd0);
    check("p1_ovr", 32'(ovr), 32'd0);
    feed(0, 1024, 4, 0);
    check("p2_ovr", 32'(ovr), 32'd1);
    check("p2_nopub", 32'(bdr), 32'd0);
    check("p2_cnt", 32'(rises - r0), 32'd1);
    busy = 1'b0;
    tick(1);
    check("p1_pub", 32'(bdr), 32'd1);
    tick(20);
    rd("p1_10", 10'h010, 8'h55);
    rd("p1_ff", 10'h0FF, 8'h55);
    feed(0, 1024, 5, 0);
    check("p3_pub", 32'(bdr), 32'd1);
    tick(20);
    rd("p3_80", 10'h080, 8'hFF);
    check("p_cnt", 32'(rises - r0), 32'd3);
    check("p_ovr_sticky", 32'(ovr), 32'd1);

    // NewRunReset during HOLD
    req = 1'b1;
    off = 10'h000;
    tick(3);
    check("nrr_hold", 32'(rdy), 32'd1);
    nrr = 1'b1;
    tick(1);
    check("nrr_rdy", 32'(rdy), 32'd0);
    check("nrr_ovr", 32'(ovr), 32'd0);
    check("nrr_data", 32'(rres), 32'd0);
    check("nrr_bdr", 32'(bdr), 32'd0);
    check("nrr_fd", 32'(fdone), 32'd0);
    nrr = 1'b0;
    req = 1'b0;
    tick(5);

    // full frame
    fs_pulse();
    r0 = rises;
    f0 = fdc;
    feed(0, 16384, 0, 0);
    check("ff_pub15", 32'(bdr), 32'd1);
    check("ff_done", 32'(fdone), 32'd1);
    tick(1);
    check("ff_done_end", 32'(fdone), 32'd0);
    feed(0, 1024, 0, 0);
    tick(40);
    check("ff_pulses", 32'(rises - r0), 32'd16);
    check("ff_donecnt", 32'(fdc - f0), 32'd1);
    check("ff_extra", 32'(bdr), 32'd0);

    // Frame_Start mid-block, restart coinciding with first pixel
    fs_pulse();
    feed(0, 3 * 128 + 50, 1, 0);
    r0 = rises;
    feed(0, 1023, 1, 1);
    check("mid_nostale", 32'(rises - r0), 32'd0);
    check("mid_low", 32'(bdr), 32'd0);
    feed(1023, 1, 1, 0);
    check("mid_pub", 32'(bdr), 32'd1);
    tick(20);
    check("mid_cnt", 32'(rises - r0), 32'd1);
    rd("mid00", 10'h000, 8'h00);
    rd("mid05", 10'h005, 8'h05);
    rd("mid63", 10'h063, 8'h63);
    rd("midff", 10'h0FF, 8'hFF);

    check("pulse_min_hi", 32'(min_hi), 32'd16);
    check("pulse_max_hi", 32'(max_hi), 32'd16);
    check("pulse_gap", 32'(min_gap >= 16), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
